// File: rtl/issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : issue_scheduler
// Description : Lockstep bundle issue controller. Pops one {DMA, arith, cache}
//               bundle per cycle on a shared read enable and issues all of its
//               active slots atomically once every needed unit can accept.
//               A blocked bundle is parked in a hold register until it issues.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_scheduler #(
  parameter int DMA_W   = 22,
  parameter int ARITH_W = 5,
  parameter int CACHE_W = 17,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               q_re,
  input  logic               q_empty,
  input  logic [DMA_W-1:0]   q_dma,
  input  logic [ARITH_W-1:0] q_arith,
  input  logic [CACHE_W-1:0] q_cache,
  input  logic               dma_busy,
  input  logic               arith_busy,
  input  logic               cache_busy,
  output logic               dma_valid,
  output logic [DMA_W-1:0]   dma_instr,
  output logic               arith_valid,
  output logic [ARITH_W-1:0] arith_instr,
  output logic               cache_valid,
  output logic [CACHE_W-1:0] cache_instr,
  output logic               running,
  output logic               done,
  output logic [CNT_W-1:0]   bundle_count,
  output logic [CNT_W-1:0]   stall_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]         state_q, state_d;
  logic               rd_pending_q;
  logic [DMA_W-1:0]   hold_dma_q, hold_dma_d;
  logic [ARITH_W-1:0] hold_arith_q, hold_arith_d;
  logic [CACHE_W-1:0] hold_cache_q, hold_cache_d;
  logic [CNT_W-1:0]   bundle_count_q, bundle_count_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;

  logic               present;
  logic [DMA_W-1:0]   src_dma;
  logic [ARITH_W-1:0] src_arith;
  logic [CACHE_W-1:0] src_cache;
  logic               need_dma, need_arith, need_cache;
  logic               can_issue;
  logic               fire;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + C_CNT_ONE);
  endfunction

  // Select the bundle under consideration and decide whether it can issue.
  always_comb begin
    present    = ((state_q == S_FETCH) && rd_pending_q) || (state_q == S_HOLD);
    src_dma    = (state_q == S_HOLD) ? hold_dma_q   : q_dma;
    src_arith  = (state_q == S_HOLD) ? hold_arith_q : q_arith;
    src_cache  = (state_q == S_HOLD) ? hold_cache_q : q_cache;
    need_dma   = src_dma[DMA_W-1];
    need_arith = src_arith[ARITH_W-1];
    need_cache = src_cache[CACHE_W-1];
    can_issue  = !((need_dma && dma_busy) || (need_arith && arith_busy) ||
                   (need_cache && cache_busy));
    fire       = present && can_issue;
  end

  // Issue strobes and instruction buses; buses are zero whenever not issuing.
  always_comb begin
    dma_valid    = fire && need_dma;
    arith_valid  = fire && need_arith;
    cache_valid  = fire && need_cache;
    dma_instr    = dma_valid   ? src_dma   : {DMA_W{1'b0}};
    arith_instr  = arith_valid ? src_arith : {ARITH_W{1'b0}};
    cache_instr  = cache_valid ? src_cache : {CACHE_W{1'b0}};
    // A new read is only safe when the current head (if any) leaves this cycle.
    q_re         = (state_q == S_FETCH) && !q_empty && (!rd_pending_q || can_issue);
    running      = (state_q == S_FETCH) || (state_q == S_HOLD) || (state_q == S_DRAIN);
    done         = (state_q == S_DONE);
    bundle_count = bundle_count_q;
    stall_count  = stall_count_q;
  end

  // Run sequencing, hold-register capture and perf counter updates.
  always_comb begin
    state_d        = state_q;
    hold_dma_d     = hold_dma_q;
    hold_arith_d   = hold_arith_q;
    hold_cache_d   = hold_cache_q;
    bundle_count_d = bundle_count_q;
    stall_count_d  = stall_count_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d        = S_FETCH;
          bundle_count_d = '0;
          stall_count_d  = '0;
        end
      end
      S_FETCH: begin
        if (rd_pending_q) begin
          if (can_issue) begin
            bundle_count_d = sat_inc(bundle_count_q);
          end else begin
            hold_dma_d    = q_dma;
            hold_arith_d  = q_arith;
            hold_cache_d  = q_cache;
            stall_count_d = sat_inc(stall_count_q);
            state_d       = S_HOLD;
          end
        end else if (q_empty) begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (can_issue) begin
          bundle_count_d = sat_inc(bundle_count_q);
          state_d        = S_FETCH;
        end else begin
          stall_count_d = sat_inc(stall_count_q);
        end
      end
      S_DRAIN: begin
        if (!dma_busy && !arith_busy && !cache_busy) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, read-pending flag, hold register and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      rd_pending_q   <= 1'b0;
      hold_dma_q     <= '0;
      hold_arith_q   <= '0;
      hold_cache_q   <= '0;
      bundle_count_q <= '0;
      stall_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      rd_pending_q   <= q_re;
      hold_dma_q     <= hold_dma_d;
      hold_arith_q   <= hold_arith_d;
      hold_cache_q   <= hold_cache_d;
      bundle_count_q <= bundle_count_d;
      stall_count_q  <= stall_count_d;
    end
  end

endmodule
`default_nettype wire
